// File: rtl/mem_tester_pkg.sv
// Shared types and LFSR constants for the DDR3 memory tester.
package mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_DATA,
    ST_DONE
  } mem_tester_state_t;

  typedef enum logic [1:0] {
    MODE_ADDR,
    MODE_LFSR,
    MODE_WALK1,
    MODE_INV_ADDR
  } mem_tester_mode_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  // Right-shifting Galois step: the polynomial mask is folded in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/ddr3_mem_tester_if.sv
// Avalon-MM local interface between the memory tester (master) and the DDR3 controller (slave).
interface ddr3_mem_tester_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 24
);
  logic                      avl_ready;
  logic                      avl_burstbegin;
  logic [ADDR_WIDTH-1:0]     avl_addr;
  logic [DATA_WIDTH-1:0]     avl_wdata;
  logic [DATA_WIDTH/8-1:0]   avl_be;
  logic                      avl_read_req;
  logic                      avl_write_req;
  logic [6:0]                avl_size;
  logic                      avl_rdata_valid;
  logic [DATA_WIDTH-1:0]     avl_rdata;

  modport master (
    input  avl_ready, avl_rdata_valid, avl_rdata,
    output avl_burstbegin, avl_addr, avl_wdata, avl_be, avl_read_req, avl_write_req, avl_size
  );

  modport slave (
    output avl_ready, avl_rdata_valid, avl_rdata,
    input  avl_burstbegin, avl_addr, avl_wdata, avl_be, avl_read_req, avl_write_req, avl_size
  );
endinterface

// File: rtl/mem_tester_pattern_gen.sv
// Test pattern generator shared by the write and compare paths; the output word is combinational,
// only the LFSR state is registered.
module mem_tester_pattern_gen
  import mem_tester_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  mem_tester_mode_t      i_mode,
  input  logic [31:0]           i_index,
  input  logic                  i_lfsr_restart,
  input  logic                  i_lfsr_step,
  output logic [DATA_WIDTH-1:0] o_pattern
);

  localparam int LANES = DATA_WIDTH / 32;

  logic [31:0] r_lfsr;
  logic [31:0] w_bit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_lfsr_restart) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_lfsr_step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  always_comb begin
    o_pattern = '0;
    w_bit     = i_index % 32'(DATA_WIDTH);
    for (int k = 0; k < LANES; k++) begin
      case (i_mode)
        MODE_ADDR:     o_pattern[k*32 +: 32] = i_index ^ 32'(k);
        MODE_LFSR:     o_pattern[k*32 +: 32] = r_lfsr ^ 32'(k);
        MODE_INV_ADDR: o_pattern[k*32 +: 32] = ~(i_index ^ 32'(k));
        default:       o_pattern[k*32 +: 32] = 32'h0;
      endcase
    end
    if (i_mode == MODE_WALK1) begin
      o_pattern = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << w_bit;
    end
  end

endmodule

// File: rtl/ddr3_mem_tester.sv
// DDR3 memory tester: waits for calibration, writes a region in bursts, reads it back and compares.
// Optional error logging (fail_addr / fail_count) is built when MEM_TESTER_ERR_LOG_EN is defined.
module ddr3_mem_tester
  import mem_tester_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN  = 4,
  parameter int ADDR_BASE  = 0,
  parameter int ADDR_COUNT = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic                  ddr3_init_done,
  input  logic                  ddr3_cal_success,
  input  logic                  ddr3_cal_fail,
  ddr3_mem_tester_if.master     avl,
  output logic                  is_finished,
  output logic                  pass,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [15:0]           fail_count
);

  mem_tester_state_t     r_state, w_next_state;
  mem_tester_mode_t      r_mode;
  logic [31:0]           r_index;
  logic [6:0]            r_beat;
  logic [ADDR_WIDTH-1:0] r_burst_addr;
  logic                  r_err, r_cal_fail;

  logic                  w_start, w_wr_acc, w_rd_beat, w_xfer, w_restart;
  logic                  w_burst_last, w_region_last, w_mismatch;
  logic [DATA_WIDTH-1:0] w_pattern;

  assign w_burst_last  = (r_beat == 7'(BURST_LEN - 1));
  assign w_region_last = (r_index == 32'(ADDR_COUNT - 1));
  assign w_xfer        = w_wr_acc | w_rd_beat;

  mem_tester_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern (
    .i_clk          (clk),
    .i_rst_n        (reset_n),
    .i_mode         (r_mode),
    .i_index        (r_index),
    .i_lfsr_restart (w_restart),
    .i_lfsr_step    (w_xfer),
    .o_pattern      (w_pattern)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_wr_acc     = 1'b0;
    w_rd_beat    = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ddr3_cal_fail) begin
          w_next_state = ST_DONE;
        end else if (ddr3_init_done && ddr3_cal_success) begin
          w_next_state = ST_WRITE;
          w_start      = 1'b1;
          w_restart    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (avl.avl_ready) begin
          w_wr_acc = 1'b1;
          if (w_region_last) begin
            w_next_state = ST_READ_REQ;
            w_restart    = 1'b1;
          end
        end
      end
      ST_READ_REQ: begin
        if (avl.avl_ready) w_next_state = ST_READ_DATA;
      end
      ST_READ_DATA: begin
        if (avl.avl_rdata_valid) begin
          w_rd_beat = 1'b1;
          if (w_burst_last) w_next_state = w_region_last ? ST_DONE : ST_READ_REQ;
        end
      end
      ST_DONE: ;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Data returned while no read burst is expected is always an error.
  assign w_mismatch = avl.avl_rdata_valid &&
                      ((r_state != ST_READ_DATA) || (avl.avl_rdata != w_pattern));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode       <= MODE_ADDR;
      r_index      <= '0;
      r_beat       <= '0;
      r_burst_addr <= ADDR_WIDTH'(ADDR_BASE);
      r_err        <= 1'b0;
      r_cal_fail   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && ddr3_cal_fail) r_cal_fail <= 1'b1;
      if (w_start) begin
        r_mode       <= mem_tester_mode_t'(mode);
        r_index      <= '0;
        r_beat       <= '0;
        r_burst_addr <= ADDR_WIDTH'(ADDR_BASE);
      end
      if (w_xfer) begin
        r_index <= r_index + 32'd1;
        r_beat  <= w_burst_last ? 7'd0 : r_beat + 7'd1;
        if (w_burst_last) r_burst_addr <= r_burst_addr + ADDR_WIDTH'(BURST_LEN);
        if (w_wr_acc && w_region_last) begin
          r_index      <= '0;
          r_burst_addr <= ADDR_WIDTH'(ADDR_BASE);
        end
      end
      if (w_mismatch) r_err <= 1'b1;
    end
  end

  assign avl.avl_write_req  = (r_state == ST_WRITE);
  assign avl.avl_read_req   = (r_state == ST_READ_REQ);
  assign avl.avl_burstbegin = ((r_state == ST_WRITE) && (r_beat == 7'd0)) || (r_state == ST_READ_REQ);
  assign avl.avl_addr       = ((r_state == ST_WRITE) || (r_state == ST_READ_REQ)) ? r_burst_addr : '0;
  assign avl.avl_wdata      = (r_state == ST_WRITE) ? w_pattern : '0;
  assign avl.avl_be         = '1;
  assign avl.avl_size       = 7'(BURST_LEN);

  assign is_finished = (r_state == ST_DONE);
  assign fail        = (r_state == ST_DONE) && (r_err || r_cal_fail);
  assign pass        = (r_state == ST_DONE) && !(r_err || r_cal_fail);

`ifdef MEM_TESTER_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [15:0]           r_fail_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fail_addr  <= '0;
      r_fail_count <= '0;
    end else if (w_mismatch) begin
      if (!r_err) r_fail_addr <= ADDR_WIDTH'(ADDR_BASE) + ADDR_WIDTH'(r_index);
      if (r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
    end
  end

  assign fail_addr  = r_fail_addr;
  assign fail_count = r_fail_count;
`else
  assign fail_addr  = '0;
  assign fail_count = '0;
`endif

endmodule

// File: tb/tb_ddr3_mem_tester.sv
// Directed bench: a 16-word tester with fault/stall control and a 128-word tester sharing its controls.
module tb_ddr3_mem_tester;
  logic clk = 1'b0;
  logic reset_n, init_done, cal_ok, cal_fail, stall, flip;
  logic [1:0] mode;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int CNT = (g == 0) ? 16 : 128;
    ddr3_mem_tester_if #(.DATA_WIDTH(64), .ADDR_WIDTH(24)) ifc ();
    logic        finished, pass_o, fail_o;
    logic [23:0] faddr;
    logic [15:0] fcnt;

    ddr3_mem_tester #(
      .DATA_WIDTH(64), .ADDR_WIDTH(24), .BURST_LEN(4), .ADDR_BASE(0), .ADDR_COUNT(CNT)
    ) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode),
      .ddr3_init_done(init_done), .ddr3_cal_success(cal_ok), .ddr3_cal_fail(cal_fail),
      .avl(ifc), .is_finished(finished), .pass(pass_o), .fail(fail_o),
      .fail_addr(faddr), .fail_count(fcnt)
    );

    logic [63:0] mem  [128];
    logic [63:0] wlog [128];
    logic [23:0] alog [32];
    int          wcnt, bcnt;
    logic        seen_wreq, rv;
    logic [6:0]  wbeat, raddr;
    logic [2:0]  rcnt;
    logic [63:0] rd;
    wire  [6:0]  woff = ifc.avl_burstbegin ? 7'd0 : wbeat;

    assign ifc.avl_ready       = (g == 0) ? ~stall : 1'b1;
    assign ifc.avl_rdata_valid = rv;
    assign ifc.avl_rdata       = rd;

    always @(posedge clk) begin
      if (!reset_n) begin
        wcnt <= 0; bcnt <= 0; wbeat <= '0; rcnt <= '0; rv <= 1'b0; rd <= '0;
        raddr <= '0; seen_wreq <= 1'b0;
      end else begin
        if (ifc.avl_write_req) seen_wreq <= 1'b1;
        if (ifc.avl_write_req && ifc.avl_ready) begin
          mem[ifc.avl_addr[6:0] + woff] <= ifc.avl_wdata;
          wlog[wcnt[6:0]] <= ifc.avl_wdata;
          wcnt  <= wcnt + 1;
          wbeat <= woff + 7'd1;
          if (ifc.avl_burstbegin) begin
            alog[bcnt[4:0]] <= ifc.avl_addr;
            bcnt <= bcnt + 1;
          end
        end
        rv <= 1'b0;
        if (rcnt != 3'd0) begin
          rv    <= 1'b1;
          rd    <= mem[raddr] ^ ((g == 0 && flip && raddr == 7'd9) ? 64'h8 : 64'h0);
          raddr <= raddr + 7'd1;
          rcnt  <= rcnt - 3'd1;
        end
        if (ifc.avl_read_req && ifc.avl_ready) begin
          rcnt  <= 3'd4;
          raddr <= ifc.avl_addr[6:0];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(g_i[0].finished && g_i[1].finished) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_budget", 64'(g_i[0].finished && g_i[1].finished), 64'd1);
  endtask

  task automatic restart(input logic [1:0] m);
    @(negedge clk);
    reset_n = 1'b0;
    mode    = m;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wreq"},  64'(g_i[0].ifc.avl_write_req),  64'd0);
    chk({tag, "_rreq"},  64'(g_i[0].ifc.avl_read_req),   64'd0);
    chk({tag, "_bb"},    64'(g_i[0].ifc.avl_burstbegin), 64'd0);
    chk({tag, "_addr"},  64'(g_i[0].ifc.avl_addr),       64'd0);
    chk({tag, "_wdata"}, g_i[0].ifc.avl_wdata,           64'd0);
    chk({tag, "_be"},    64'(g_i[0].ifc.avl_be),         64'hFF);
    chk({tag, "_size"},  64'(g_i[0].ifc.avl_size),       64'd4);
    chk({tag, "_fin"},   64'(g_i[0].finished),           64'd0);
    chk({tag, "_pass"},  64'(g_i[0].pass_o),             64'd0);
    chk({tag, "_fail"},  64'(g_i[0].fail_o),             64'd0);
    chk({tag, "_faddr"}, 64'(g_i[0].faddr),              64'd0);
    chk({tag, "_fcnt"},  64'(g_i[0].fcnt),               64'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; mode = 2'd0; init_done = 1'b0; cal_ok = 1'b0; cal_fail = 1'b0;
    stall = 1'b0; flip = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");

    // Mode 0 on ideal memory
    init_done = 1'b1; cal_ok = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_beat_wreq",  64'(g_i[0].ifc.avl_write_req),  64'd1);
    chk("first_beat_bb",    64'(g_i[0].ifc.avl_burstbegin), 64'd1);
    chk("first_beat_wdata", g_i[0].ifc.avl_wdata,           64'h00000001_00000000);
    wait_done(1000);
    chk("m0_burst0", 64'(g_i[0].alog[0]), 64'd0);
    chk("m0_burst1", 64'(g_i[0].alog[1]), 64'd4);
    chk("m0_burst2", 64'(g_i[0].alog[2]), 64'd8);
    chk("m0_burst3", 64'(g_i[0].alog[3]), 64'd12);
    chk("m0_nburst", 64'(g_i[0].bcnt),    64'd4);
    chk("m0_nbeats", 64'(g_i[0].wcnt),    64'd16);
    chk("m0_word5",  g_i[0].wlog[5],      64'h00000004_00000005);
    chk("m0_pass",   64'(g_i[0].pass_o),  64'd1);
    chk("m0_fail",   64'(g_i[0].fail_o),  64'd0);
    chk("m0_fcnt",   64'(g_i[0].fcnt),    64'd0);
    chk("m0_b_pass", 64'(g_i[1].pass_o),  64'd1);

    // Bit 3 of word 9 corrupted on read-back
    flip = 1'b1;
    restart(2'd0);
    wait_done(1000);
    chk("flip_fail", 64'(g_i[0].fail_o), 64'd1);
    chk("flip_pass", 64'(g_i[0].pass_o), 64'd0);
`ifdef MEM_TESTER_ERR_LOG_EN
    chk("flip_faddr", 64'(g_i[0].faddr), 64'd9);
    chk("flip_fcnt",  64'(g_i[0].fcnt),  64'd1);
`else
    chk("flip_faddr", 64'(g_i[0].faddr), 64'd0);
    chk("flip_fcnt",  64'(g_i[0].fcnt),  64'd0);
`endif
    chk("flip_b_pass", 64'(g_i[1].pass_o), 64'd1);
    flip = 1'b0;

    // Calibration failure while idle
    @(negedge clk);
    reset_n = 1'b0; init_done = 1'b0; cal_ok = 1'b0; cal_fail = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("calf_fin",  64'(g_i[0].finished),  64'd1);
    chk("calf_fail", 64'(g_i[0].fail_o),    64'd1);
    chk("calf_pass", 64'(g_i[0].pass_o),    64'd0);
    chk("calf_nowr", 64'(g_i[0].seen_wreq), 64'd0);
    cal_fail = 1'b0; init_done = 1'b1; cal_ok = 1'b1;

    // Controller stalls for 5 cycles on write beat 2
    restart(2'd0);
    n = 0;
    while (!(g_i[0].ifc.avl_write_req && g_i[0].wcnt == 2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached", 64'(g_i[0].wcnt), 64'd2);
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_wdata", g_i[0].ifc.avl_wdata,              64'h00000003_00000002);
      chk("stall_addr",  64'(g_i[0].ifc.avl_addr),          64'd0);
      chk("stall_wreq",  64'(g_i[0].ifc.avl_write_req),     64'd1);
    end
    chk("stall_nbeats_held", 64'(g_i[0].wcnt), 64'd2);
    stall = 1'b0;
    wait_done(1000);
    chk("stall_nbeats", 64'(g_i[0].wcnt),   64'd16);
    chk("stall_pass",   64'(g_i[0].pass_o), 64'd1);

    // LFSR mode
    restart(2'd1);
    wait_done(1000);
    chk("m1_word0",  g_i[0].wlog[0],     64'hACE10000_ACE10001);
    chk("m1_word1",  g_i[0].wlog[1],     64'hD6508002_D6508003);
    chk("m1_pass",   64'(g_i[0].pass_o), 64'd1);
    chk("m1_b_pass", 64'(g_i[1].pass_o), 64'd1);

    // Walking-one mode
    restart(2'd2);
    wait_done(1000);
    chk("m2_word5",   g_i[0].wlog[5],     64'h00000000_00000020);
    chk("m2_word63",  g_i[1].wlog[63],    64'h80000000_00000000);
    chk("m2_word70",  g_i[1].wlog[70],    64'h00000000_00000040);
    chk("m2_pass",    64'(g_i[0].pass_o), 64'd1);
    chk("m2_b_pass",  64'(g_i[1].pass_o), 64'd1);

    // Inverted-address mode
    restart(2'd3);
    wait_done(1000);
    chk("m3_word5",  g_i[0].wlog[5],     64'hFFFFFFFB_FFFFFFFA);
    chk("m3_pass",   64'(g_i[0].pass_o), 64'd1);
    chk("m3_b_pass", 64'(g_i[1].pass_o), 64'd1);

    // Asynchronous reset in the middle of a read burst
    restart(2'd0);
    n = 0;
    while (!g_i[0].ifc.avl_rdata_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_read_reached", 64'(g_i[0].ifc.avl_rdata_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_done(1000);
    chk("midrst_burst0", 64'(g_i[0].alog[0]), 64'd0);
    chk("midrst_nbeats", 64'(g_i[0].wcnt),    64'd16);
    chk("midrst_pass",   64'(g_i[0].pass_o),  64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
